// File: rtl/multi_mode_cntr_if.sv
// Control and status bundle for multi_mode_cntr: the master drives the
// count controls and the slave (the counter) returns count and status.
`timescale 1ns/1ps

interface multi_mode_cntr_if #(
    parameter int WIDTH = 10
);
    logic             iCntRst_n;
    logic             iCntEn;
    logic             iDir;
    logic [1:0]       iMode;
    logic [WIDTH-1:0] iTerm;
    logic             iLoad;
    logic [WIDTH-1:0] iLoadVal;
    logic [WIDTH-1:0] oCntr;
    logic             oCntDone;
    logic             oTermPulse;
    logic             oArmed;

    modport master (
        output iCntRst_n, iCntEn, iDir, iMode, iTerm, iLoad, iLoadVal,
        input  oCntr, oCntDone, oTermPulse, oArmed
    );

    modport slave (
        input  iCntRst_n, iCntEn, iDir, iMode, iTerm, iLoad, iLoadVal,
        output oCntr, oCntDone, oTermPulse, oArmed
    );
endinterface

// File: rtl/multi_mode_cntr.sv
// Up/down counter with saturate, wrap and one-shot modes, synchronous load and terminal pulse.
// Optional count prescaler is compiled in when CNTR_PRESCALE_EN is defined.
`timescale 1ns/1ps

module multi_mode_cntr #(
    parameter int WIDTH        = 10,
    parameter int PRESCALE_DIV = 4
) (
    input  logic               iClk,
    input  logic               iRst_n,
    multi_mode_cntr_if.slave   cntIf
);
    typedef enum logic [1:0] {
        MODE_SAT     = 2'b00,
        MODE_WRAP    = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_SAT_ALT = 2'b11
    } mode_t;

    mode_t            mode;
    logic             cntDone;
    logic             stepEn;
    logic             stepAct;
    logic             nextDone;
    logic [WIDTH-1:0] nextCntr;

    assign mode           = mode_t'(cntIf.iMode);
    assign cntDone        = cntIf.iDir ? (cntIf.oCntr >= cntIf.iTerm) : (cntIf.oCntr == '0);
    assign cntIf.oCntDone = cntDone;

`ifdef CNTR_PRESCALE_EN
    localparam int             PRE_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] preCnt;

    assign stepEn = cntIf.iCntEn && (preCnt == PRE_LAST);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            preCnt <= '0;
        else if (!cntIf.iCntRst_n || cntIf.iLoad)
            preCnt <= '0;
        else if (cntIf.iCntEn)
            preCnt <= (preCnt == PRE_LAST) ? '0 : preCnt + PRE_W'(1);
    end
`else
    assign stepEn = cntIf.iCntEn;
`endif

    // A disarmed one-shot ignores steps until a load or clear re-arms it.
    assign stepAct = stepEn && !(mode == MODE_ONESHOT && !cntIf.oArmed);

    // NOTE: default first so every path assigns nextCntr and no latch is inferred.
    always_comb begin
        nextCntr = cntIf.oCntr;
        if (!cntDone)
            nextCntr = cntIf.iDir ? cntIf.oCntr + WIDTH'(1) : cntIf.oCntr - WIDTH'(1);
        else if (mode == MODE_WRAP)
            nextCntr = cntIf.iDir ? '0 : cntIf.iTerm;
    end

    assign nextDone = cntIf.iDir ? (nextCntr >= cntIf.iTerm) : (nextCntr == '0);

    // NOTE: registers update with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cntIf.oCntr      <= '0;
            cntIf.oTermPulse <= 1'b0;
            cntIf.oArmed     <= 1'b1;
        end else begin
            cntIf.oTermPulse <= 1'b0;
            if (!cntIf.iCntRst_n) begin
                cntIf.oCntr  <= '0;
                cntIf.oArmed <= 1'b1;
            end else if (cntIf.iLoad) begin
                cntIf.oCntr  <= cntIf.iLoadVal;
                cntIf.oArmed <= 1'b1;
            end else if (stepAct) begin
                cntIf.oCntr      <= nextCntr;
                // Pulse only on arrival; holding at or wrapping away from the target is silent.
                cntIf.oTermPulse <= !cntDone && nextDone;
                if (mode == MODE_ONESHOT && nextDone)
                    cntIf.oArmed <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multi_mode_cntr.sv
// Scoreboard bench for multi_mode_cntr: expected state is queued when stimulus is
// driven and compared after the edge(s) that should produce it.
`timescale 1ns/1ps

module tb_multi_mode_cntr;
    localparam int WIDTH = 10;
`ifdef CNTR_PRESCALE_EN
    localparam int STEP_EDGES = 4;
`else
    localparam int STEP_EDGES = 1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] cntr;
        logic             pulse;
        logic             done;
        logic             armed;
    } exp_t;

    logic  iClk = 1'b0;
    logic  iRst_n = 1'b0;
    exp_t  expQ[$];
    int    nChecks = 0;
    int    nFails = 0;
    string curTest = "reset";

    multi_mode_cntr_if #(.WIDTH(WIDTH)) cntIf ();

    multi_mode_cntr #(.WIDTH(WIDTH), .PRESCALE_DIV(4)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .cntIf  (cntIf.slave)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFails++;
            $display("FAIL %s/%s: got %0d expected %0d", curTest, tag, obs, expv);
        end
    endtask

    task automatic compareOut(input exp_t e);
        check("oCntr",      32'(cntIf.oCntr),      32'(e.cntr));
        check("oTermPulse", 32'(cntIf.oTermPulse), 32'(e.pulse));
        check("oCntDone",   32'(cntIf.oCntDone),   32'(e.done));
        check("oArmed",     32'(cntIf.oArmed),     32'(e.armed));
    endtask

    // Called at a falling edge with inputs already set; nEdges=0 means one count step.
    task automatic tick(input logic [WIDTH-1:0] c, input logic p, input logic d,
                        input logic a, input int nEdges = 0);
        exp_t e;
        int   n;
        e.cntr  = c;
        e.pulse = p;
        e.done  = d;
        e.armed = a;
        expQ.push_back(e);
        n = nEdges;
        if (n == 0)
            n = (cntIf.iCntEn && cntIf.iCntRst_n && !cntIf.iLoad) ? STEP_EDGES : 1;
        repeat (n) begin
            @(posedge iClk);
            @(negedge iClk);
        end
        e = expQ.pop_front();
        compareOut(e);
    endtask

    task automatic setIn(input logic cntRst_n, input logic en, input logic dir,
                         input logic [1:0] mode, input logic [WIDTH-1:0] term,
                         input logic load, input logic [WIDTH-1:0] loadVal);
        cntIf.iCntRst_n = cntRst_n;
        cntIf.iCntEn    = en;
        cntIf.iDir      = dir;
        cntIf.iMode     = mode;
        cntIf.iTerm     = term;
        cntIf.iLoad     = load;
        cntIf.iLoadVal  = loadVal;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        setIn(1'b1, 1'b0, 1'b1, 2'b00, 10'd5, 1'b0, 10'd0);
        repeat (2) @(negedge iClk);
        compareOut('{cntr: 10'd0, pulse: 1'b0, done: 1'b0, armed: 1'b1});
        iRst_n = 1'b1;

        curTest = "sat_up";
        cntIf.iCntEn = 1'b1;
        for (int i = 1; i <= 4; i++) tick(10'(i), 1'b0, 1'b0, 1'b1);
        tick(10'd5, 1'b1, 1'b1, 1'b1);
        tick(10'd5, 1'b0, 1'b1, 1'b1);
        tick(10'd5, 1'b0, 1'b1, 1'b1);

        curTest = "wrap_up";
        setIn(1'b0, 1'b1, 1'b1, 2'b01, 10'd3, 1'b0, 10'd0);
        tick(10'd0, 1'b0, 1'b0, 1'b1);
        cntIf.iCntRst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick(10'd1, 1'b0, 1'b0, 1'b1);
            tick(10'd2, 1'b0, 1'b0, 1'b1);
            tick(10'd3, 1'b1, 1'b1, 1'b1);
            tick(10'd0, 1'b0, 1'b0, 1'b1);
        end

        curTest = "wrap_down";
        setIn(1'b1, 1'b0, 1'b0, 2'b01, 10'd3, 1'b1, 10'd2);
        tick(10'd2, 1'b0, 1'b0, 1'b1);
        cntIf.iLoad  = 1'b0;
        cntIf.iCntEn = 1'b1;
        tick(10'd1, 1'b0, 1'b0, 1'b1);
        tick(10'd0, 1'b1, 1'b1, 1'b1);
        tick(10'd3, 1'b0, 1'b0, 1'b1);
        tick(10'd2, 1'b0, 1'b0, 1'b1);
        tick(10'd1, 1'b0, 1'b0, 1'b1);
        tick(10'd0, 1'b1, 1'b1, 1'b1);

        curTest = "oneshot";
        setIn(1'b1, 1'b0, 1'b1, 2'b10, 10'd4, 1'b1, 10'd0);
        tick(10'd0, 1'b0, 1'b0, 1'b1);
        cntIf.iLoad  = 1'b0;
        cntIf.iCntEn = 1'b1;
        for (int i = 1; i <= 3; i++) tick(10'(i), 1'b0, 1'b0, 1'b1);
        tick(10'd4, 1'b1, 1'b1, 1'b0);
        tick(10'd4, 1'b0, 1'b1, 1'b0);
        cntIf.iTerm = 10'd6;
        tick(10'd4, 1'b0, 1'b0, 1'b0);
        tick(10'd4, 1'b0, 1'b0, 1'b0);
        cntIf.iLoad = 1'b1;
        tick(10'd0, 1'b0, 1'b0, 1'b1);
        cntIf.iLoad = 1'b0;
        for (int i = 1; i <= 5; i++) tick(10'(i), 1'b0, 1'b0, 1'b1);
        tick(10'd6, 1'b1, 1'b1, 1'b0);

        curTest = "load_edges";
        setIn(1'b1, 1'b0, 1'b1, 2'b00, 10'd5, 1'b1, 10'd5);
        tick(10'd5, 1'b0, 1'b1, 1'b1);
        cntIf.iLoadVal = 10'd9;
        tick(10'd9, 1'b0, 1'b1, 1'b1);
        cntIf.iLoad  = 1'b0;
        cntIf.iCntEn = 1'b1;
        tick(10'd9, 1'b0, 1'b1, 1'b1);
        cntIf.iMode = 2'b01;
        tick(10'd0, 1'b0, 1'b0, 1'b1);

        curTest = "term_zero";
        cntIf.iTerm = 10'd0;
        tick(10'd0, 1'b0, 1'b1, 1'b1);
        tick(10'd0, 1'b0, 1'b1, 1'b1);
        cntIf.iMode = 2'b00;
        tick(10'd0, 1'b0, 1'b1, 1'b1);
        cntIf.iTerm = 10'd2;
        tick(10'd1, 1'b0, 1'b0, 1'b1);
        cntIf.iMode = 2'b11;
        tick(10'd2, 1'b1, 1'b1, 1'b1);
        tick(10'd2, 1'b0, 1'b1, 1'b1);

        curTest = "wrap_max";
        setIn(1'b1, 1'b0, 1'b1, 2'b01, 10'd1023, 1'b1, 10'd1022);
        tick(10'd1022, 1'b0, 1'b0, 1'b1);
        cntIf.iLoad  = 1'b0;
        cntIf.iCntEn = 1'b1;
        tick(10'd1023, 1'b1, 1'b1, 1'b1);
        tick(10'd0, 1'b0, 1'b0, 1'b1);

        curTest = "clr_prio";
        setIn(1'b1, 1'b0, 1'b1, 2'b00, 10'd5, 1'b1, 10'd3);
        tick(10'd3, 1'b0, 1'b0, 1'b1);
        setIn(1'b0, 1'b1, 1'b1, 2'b00, 10'd5, 1'b1, 10'd7);
        tick(10'd0, 1'b0, 1'b0, 1'b1);

        curTest = "async_rst";
        setIn(1'b1, 1'b0, 1'b1, 2'b00, 10'd20, 1'b1, 10'd8);
        tick(10'd8, 1'b0, 1'b0, 1'b1);
        cntIf.iLoad  = 1'b0;
        cntIf.iCntEn = 1'b1;
        tick(10'd9, 1'b0, 1'b0, 1'b1);
        iRst_n = 1'b0;
        #1;
        compareOut('{cntr: 10'd0, pulse: 1'b0, done: 1'b0, armed: 1'b1});
        @(negedge iClk);
        setIn(1'b1, 1'b1, 1'b1, 2'b00, 10'd2, 1'b0, 10'd0);
        iRst_n = 1'b1;

        curTest = "prescale";
`ifdef CNTR_PRESCALE_EN
        for (int i = 0; i < 3; i++) tick(10'd0, 1'b0, 1'b0, 1'b1, 1);
        cntIf.iCntEn = 1'b0;
        for (int i = 0; i < 2; i++) tick(10'd0, 1'b0, 1'b0, 1'b1, 1);
        cntIf.iCntEn = 1'b1;
        tick(10'd1, 1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 3; i++) tick(10'd1, 1'b0, 1'b0, 1'b1, 1);
        tick(10'd2, 1'b1, 1'b1, 1'b1, 1);
`else
        tick(10'd1, 1'b0, 1'b0, 1'b1, 1);
        cntIf.iCntEn = 1'b0;
        tick(10'd1, 1'b0, 1'b0, 1'b1, 1);
        tick(10'd1, 1'b0, 1'b0, 1'b1, 1);
        cntIf.iCntEn = 1'b1;
        tick(10'd2, 1'b1, 1'b1, 1'b1, 1);
        tick(10'd2, 1'b0, 1'b1, 1'b1, 1);
`endif

        curTest = "scoreboard";
        check("queue_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
